// File: rtl/rf_wr_arbiter_if.sv
// Write-request, RF-write and hazard-check signals shared between the
// requesters and the register-file write arbiter.
interface rf_wr_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          r0_valid;
    logic          r0_ready;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_data;
    logic          r1_valid;
    logic          r1_ready;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_data;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;
    logic          rf_wr;
    logic [AW-1:0] chk_a1;
    logic [AW-1:0] chk_a2;
    logic          chk_pend1;
    logic          chk_pend2;
    logic          idle;

    modport master (
        output r0_valid, r0_addr, r0_data,
        output r1_valid, r1_addr, r1_data,
        output chk_a1, chk_a2,
        input  r0_ready, r1_ready,
        input  rf_a3, rf_wd, rf_wr,
        input  chk_pend1, chk_pend2, idle
    );

    modport slave (
        input  r0_valid, r0_addr, r0_data,
        input  r1_valid, r1_addr, r1_data,
        input  chk_a1, chk_a2,
        output r0_ready, r1_ready,
        output rf_a3, rf_wd, rf_wr,
        output chk_pend1, chk_pend2, idle
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Two-requester round-robin arbiter for the single register-file write port,
// with per-requester FIFOs and combinational pending-write (RAW) checks.
module rf_wr_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    rf_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [1:0]    w_in_valid;
    logic [AW-1:0] w_in_addr   [2];
    logic [DW-1:0] w_in_data   [2];
    logic [AW-1:0] w_head_addr [2];
    logic [DW-1:0] w_head_data [2];
    logic [1:0]    w_ready;
    logic [1:0]    w_empty;
    logic [1:0]    w_grant;
    logic [1:0]    w_hit1;
    logic [1:0]    w_hit2;

    logic          r_last;
    logic          r_rf_wr;
    logic [AW-1:0] r_rf_a3;
    logic [DW-1:0] r_rf_wd;

    assign w_in_valid   = {bus.r1_valid, bus.r0_valid};
    assign w_in_addr[0] = bus.r0_addr;
    assign w_in_addr[1] = bus.r1_addr;
    assign w_in_data[0] = bus.r0_data;
    assign w_in_data[1] = bus.r1_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [PW:0]      r_wptr;
            logic [PW:0]      r_rptr;
            logic [AW-1:0]    r_mem_addr [DEPTH];
            logic [DW-1:0]    r_mem_data [DEPTH];
            logic [PW:0]      w_count;
            logic             w_push;
            logic [DEPTH-1:0] w_entry_valid;
            logic [DEPTH-1:0] w_m1;
            logic [DEPTH-1:0] w_m2;

            // Pointers carry one extra wrap bit so full and empty differ.
            assign w_count          = r_wptr - r_rptr;
            assign w_empty[gi]      = (w_count == '0);
            assign w_ready[gi]      = (w_count != (PW+1)'(DEPTH));
            assign w_push           = w_in_valid[gi] && w_ready[gi];
            assign w_head_addr[gi]  = r_mem_addr[r_rptr[PW-1:0]];
            assign w_head_data[gi]  = r_mem_data[r_rptr[PW-1:0]];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_push)
                        r_wptr <= r_wptr + (PW+1)'(1);
                    if (w_grant[gi])
                        r_rptr <= r_rptr + (PW+1)'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem_addr[r_wptr[PW-1:0]] <= w_in_addr[gi];
                    r_mem_data[r_wptr[PW-1:0]] <= w_in_data[gi];
                end
            end

            // A slot is live when its distance from the read pointer is below the count.
            for (genvar gj = 0; gj < DEPTH; gj++) begin : g_ent
                logic [PW-1:0] w_off;
                assign w_off             = PW'(gj) - r_rptr[PW-1:0];
                assign w_entry_valid[gj] = ({1'b0, w_off} < w_count);
                assign w_m1[gj]          = w_entry_valid[gj] && (r_mem_addr[gj] == bus.chk_a1);
                assign w_m2[gj]          = w_entry_valid[gj] && (r_mem_addr[gj] == bus.chk_a2);
            end

            assign w_hit1[gi] = |w_m1;
            assign w_hit2[gi] = |w_m2;
        end
    endgenerate

    // r_last remembers the most recent grant; the other requester wins a tie.
    logic          w_any;
    logic          w_sel;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_data;

    assign w_grant[0] = !w_empty[0] && (w_empty[1] || r_last);
    assign w_grant[1] = !w_empty[1] && (w_empty[0] || !r_last);
    assign w_any      = |w_grant;
    assign w_sel      = w_grant[1];
    assign w_gnt_addr = w_head_addr[w_sel];
    assign w_gnt_data = w_head_data[w_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wr <= 1'b0;
            r_rf_a3 <= '0;
            r_rf_wd <= '0;
            r_last  <= 1'b1;
        end else begin
            r_rf_wr <= w_any && (w_gnt_addr != '0);
            if (w_any) begin
                r_last <= w_sel;
                // Writes to register 0 are consumed but never reach the RF.
                if (w_gnt_addr != '0) begin
                    r_rf_a3 <= w_gnt_addr;
                    r_rf_wd <= w_gnt_data;
                end
            end
        end
    end

    assign bus.r0_ready  = w_ready[0];
    assign bus.r1_ready  = w_ready[1];
    assign bus.rf_wr     = r_rf_wr;
    assign bus.rf_a3     = r_rf_a3;
    assign bus.rf_wd     = r_rf_wd;
    assign bus.chk_pend1 = (bus.chk_a1 != '0) &&
                           ((|w_hit1) || (r_rf_wr && (r_rf_a3 == bus.chk_a1)));
    assign bus.chk_pend2 = (bus.chk_a2 != '0) &&
                           ((|w_hit2) || (r_rf_wr && (r_rf_a3 == bus.chk_a2)));
    assign bus.idle      = (&w_empty) && !r_rf_wr;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected RF writes are queued in issue
// order and a negedge monitor compares every rf_wr pulse against the queue.
module tb_rf_wr_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    rf_wr_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    wr_t sb[$];
    wr_t mon_exp;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.idle === 1'b1) break;
            cyc();
        end
        check("drain_idle", 64'(bus.idle), 64'(1));
    endtask

    // Scoreboard monitor: every RF write pulse must match the next expected write.
    always @(negedge clk) begin
        if (bus.rf_wr === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual a3=%0d wd=%h required none", bus.rf_a3, bus.rf_wd);
            end else begin
                mon_exp = sb.pop_front();
                check("rf_write", 64'({bus.rf_a3, bus.rf_wd}), 64'({mon_exp.addr, mon_exp.data}));
                $display("write a3=%0d wd=%h", bus.rf_a3, bus.rf_wd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1;
        logic acc0, acc1;
        logic [5:0] exp_rdy0, exp_rdy1;

        rst = 1'b1;
        bus.r0_valid = 1'b0; bus.r0_addr = '0; bus.r0_data = '0;
        bus.r1_valid = 1'b0; bus.r1_addr = '0; bus.r1_data = '0;
        bus.chk_a1 = 5'd5;  bus.chk_a2 = 5'd0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rf_wr",  64'(bus.rf_wr),     64'(0));
        check("reset_rf_a3",  64'(bus.rf_a3),     64'(0));
        check("reset_rf_wd",  64'(bus.rf_wd),     64'(0));
        check("reset_r0_rdy", 64'(bus.r0_ready),  64'(1));
        check("reset_r1_rdy", 64'(bus.r1_ready),  64'(1));
        check("reset_idle",   64'(bus.idle),      64'(1));
        check("reset_pend1",  64'(bus.chk_pend1), 64'(0));

        // Single write with latency and pending-check timing
        bus.chk_a1 = 5'd8;
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd8; bus.r0_data = 32'hDEADBEEF;
        expect_wr(5'd8, 32'hDEADBEEF);
        cyc();
        bus.r0_valid = 1'b0;
        check("single_n_wr",    64'(bus.rf_wr),     64'(0));
        check("single_n_pend",  64'(bus.chk_pend1), 64'(1));
        cyc();
        check("single_n1_wr",   64'(bus.rf_wr),     64'(1));
        check("single_n1_a3",   64'(bus.rf_a3),     64'(8));
        check("single_n1_wd",   64'(bus.rf_wd),     64'(32'hDEADBEEF));
        check("single_n1_pend", 64'(bus.chk_pend1), 64'(1));
        cyc();
        check("single_n2_wr",   64'(bus.rf_wr),     64'(0));
        check("single_n2_pend", 64'(bus.chk_pend1), 64'(0));
        check("single_n2_idle", 64'(bus.idle),      64'(1));

        // Contention from reset priority: issue order 1,3,2,4
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        expect_wr(5'd1, 32'hA); expect_wr(5'd3, 32'hC);
        expect_wr(5'd2, 32'hB); expect_wr(5'd4, 32'hD);
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd1; bus.r0_data = 32'hA;
        bus.r1_valid = 1'b1; bus.r1_addr = 5'd3; bus.r1_data = 32'hC;
        cyc();
        check("cont_first_wr", 64'(bus.rf_wr), 64'(0));
        bus.r0_addr = 5'd2; bus.r0_data = 32'hB;
        bus.r1_addr = 5'd4; bus.r1_data = 32'hD;
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.r0_valid = 1'b0;
            bus.r1_valid = 1'b0;
            check("cont_wr_high", 64'(bus.rf_wr), 64'(1));
        end
        cyc();
        check("cont_end_wr",   64'(bus.rf_wr), 64'(0));
        check("cont_end_idle", 64'(bus.idle),  64'(1));

        // Full/backpressure with both requesters streaming
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_rdy0 = 6'b010111;
        exp_rdy1 = 6'b101011;
        expect_wr(5'd10, 32'hA0000000); expect_wr(5'd20, 32'hB0000000);
        expect_wr(5'd11, 32'hA0000001); expect_wr(5'd21, 32'hB0000001);
        expect_wr(5'd12, 32'hA0000002); expect_wr(5'd22, 32'hB0000002);
        expect_wr(5'd13, 32'hA0000003);
        p0 = 0;
        p1 = 0;
        for (int k = 0; k < 6; k++) begin
            bus.r0_valid = (k < 5);
            bus.r0_addr  = AW'(10 + p0);
            bus.r0_data  = 32'hA0000000 + DW'(p0);
            bus.r1_valid = (k < 5);
            bus.r1_addr  = AW'(20 + p1);
            bus.r1_data  = 32'hB0000000 + DW'(p1);
            check("full_r0_ready", 64'(bus.r0_ready), 64'(exp_rdy0[k]));
            check("full_r1_ready", 64'(bus.r1_ready), 64'(exp_rdy1[k]));
            acc0 = bus.r0_valid && bus.r0_ready;
            acc1 = bus.r1_valid && bus.r1_ready;
            cyc();
            if (acc0) p0++;
            if (acc1) p1++;
        end
        check("full_r0_pushes", 64'(p0), 64'(4));
        check("full_r1_pushes", 64'(p1), 64'(3));
        wait_idle(20);

        // Register-0 write is consumed but discarded
        bus.chk_a1 = 5'd9;
        bus.chk_a2 = 5'd0;
        expect_wr(5'd9, 32'h2);
        bus.r1_valid = 1'b1; bus.r1_addr = 5'd0; bus.r1_data = 32'h1;
        cyc();
        bus.r1_addr = 5'd9; bus.r1_data = 32'h2;
        check("zero_e1_wr",    64'(bus.rf_wr),     64'(0));
        check("zero_e1_pend2", 64'(bus.chk_pend2), 64'(0));
        cyc();
        bus.r1_valid = 1'b0;
        check("zero_discard",  64'(bus.rf_wr),     64'(0));
        check("zero_e2_pend1", 64'(bus.chk_pend1), 64'(1));
        check("zero_e2_pend2", 64'(bus.chk_pend2), 64'(0));
        cyc();
        check("zero_e3_wr",    64'(bus.rf_wr),     64'(1));
        check("zero_e3_a3",    64'(bus.rf_a3),     64'(9));
        check("zero_e3_pend1", 64'(bus.chk_pend1), 64'(1));
        check("zero_e3_pend2", 64'(bus.chk_pend2), 64'(0));
        cyc();
        check("zero_e4_wr",    64'(bus.rf_wr),     64'(0));
        check("zero_e4_pend1", 64'(bus.chk_pend1), 64'(0));

        // Reset mid-stream discards queued entries and restores r0 priority
        expect_wr(5'd11, 32'hC1);
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd11; bus.r0_data = 32'hC1;
        bus.r1_valid = 1'b1; bus.r1_addr = 5'd12; bus.r1_data = 32'hD1;
        cyc();
        bus.r0_addr = 5'd13; bus.r0_data = 32'hC2;
        bus.r1_addr = 5'd14; bus.r1_data = 32'hD2;
        check("mid_e1_wr", 64'(bus.rf_wr), 64'(0));
        cyc();
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        rst = 1'b1;
        check("mid_e2_wr", 64'(bus.rf_wr), 64'(1));
        cyc();
        rst = 1'b0;
        check("mid_rst_wr",   64'(bus.rf_wr),    64'(0));
        check("mid_rst_idle", 64'(bus.idle),     64'(1));
        check("mid_rst_r0",   64'(bus.r0_ready), 64'(1));
        check("mid_rst_r1",   64'(bus.r1_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mid_quiet_wr", 64'(bus.rf_wr), 64'(0));
        end
        expect_wr(5'd16, 32'hF0F0_0001);
        expect_wr(5'd15, 32'hF0F0_0002);
        bus.r0_valid = 1'b1; bus.r0_addr = 5'd16; bus.r0_data = 32'hF0F0_0001;
        bus.r1_valid = 1'b1; bus.r1_addr = 5'd15; bus.r1_data = 32'hF0F0_0002;
        cyc();
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        cyc();
        wait_idle(10);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port (A3/WD/RFWr) between two write requesters.
  - Requester 0: CPU writeback.
  - Requester 1: load-return / debug writer.
- Each requester has its own small FIFO; grants rotate round-robin; at most one write is issued per cycle.
- Provides combinational pending-write checks on the two read addresses so the multi-cycle controller can stall on RAW hazards.
- Sits between the requesters and the RF; its outputs drive the RF write inputs directly.

Parameters:
- DEPTH, 2, entries per requester FIFO; power of 2, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- r0_valid  input  1  requester 0 write request.
- r0_ready  output  1  requester 0 FIFO can accept.
- r0_addr  input  AW  requester 0 destination register.
- r0_data  input  DW  requester 0 write data.
- r1_valid  input  1  requester 1 write request.
- r1_ready  output  1  requester 1 FIFO can accept.
- r1_addr  input  AW  requester 1 destination register.
- r1_data  input  DW  requester 1 write data.
- rf_a3  output  AW  RF write address (registered).
- rf_wd  output  DW  RF write data (registered).
- rf_wr  output  1  RF write enable (registered).
- chk_a1  input  AW  read address 1 to check.
- chk_a2  input  AW  read address 2 to check.
- chk_pend1  output  1  write to chk_a1 still outstanding.
- chk_pend2  output  1  write to chk_a2 still outstanding.
- idle  output  1  both FIFOs empty and rf_wr low.

Behaviour:
- Reset (rst high at posedge):
  - Both FIFOs emptied; queued entries are discarded, even mid-stream.
  - rf_wr=0, rf_a3=0, rf_wd=0.
  - Round-robin pointer set so requester 0 has priority next.
  - rst dominates every other input that cycle.
- Ready and push:
  - rN_ready = !fullN (combinational, no dependence on rN_valid).
  - A push occurs at a posedge when rN_valid && rN_ready.
  - A full FIFO does not accept, even if it pops in the same cycle (no bypass).
- Issue:
  - At each posedge, if at least one FIFO was non-empty before the edge, exactly one head is popped.
  - If only one FIFO is non-empty, that FIFO is granted.
  - If both are non-empty, the requester not granted last time is granted; the pointer updates only on a grant.
- Output registers after a grant:
  - Granted entry with addr != 0: rf_wr=1, rf_a3=addr, rf_wd=data.
  - Granted entry with addr == 0: popped but rf_wr=0 (write discarded); the grant still counts for round-robin.
  - No grant: rf_wr=0. rf_a3 and rf_wd hold their previous values.
- Latency:
  - An entry pushed at edge N into an otherwise idle arbiter is issued at edge N+1.
  - rf_wr is high for the cycle N+1..N+2; the RF commits it on that cycle's negedge.
  - Minimum push-to-RF-commit is 1.5 cycles.
  - No combinational path from rN_* to rf_*.
- Ordering:
  - Program order is kept within a requester.
  - Across requesters, arbitration order is the commit order.
  - Same-address writes from both requesters: the later-granted write wins.
- Throughput: one write per cycle sustained; each requester receives at least every other slot under contention.
- Pending checks (combinational):
  - chk_pendK=1 iff chk_aK != 0 and chk_aK matches any valid entry in either FIFO, or matches rf_a3 while rf_wr=1.
  - An entry popped at edge N stops counting as a FIFO entry at N but counts as rf_a3 until rf_wr drops.
- idle = !valid0_any && !valid1_any && !rf_wr.
- FIFO pointers wrap modulo DEPTH. Full/empty are derived with an extra wrap bit; no count register is required.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → rf_wr=0, rf_a3=0, rf_wd=0, r0_ready=r1_ready=1, idle=1, chk_pend1=0 for chk_a1=5.
- Single write: push r0 addr=8 data=32'hDEADBEEF at edge N → rf_wr=1, rf_a3=8, rf_wd=DEADBEEF during cycle N+1 only. With chk_a1=8, chk_pend1=1 from N through N+1, then 0 at N+2.
- Contention: both FIFOs hold 2 entries (r0: 1/A,2/B; r1: 3/C,4/D) from reset priority → issue order 1,3,2,4 on consecutive cycles; rf_wr stays high for 4 cycles.
- Full/backpressure (DEPTH=2): hold r0_valid with no pops possible (r1 continuously granted alternately) → r0_ready falls after 2 pushes. Verify a push attempted on a full FIFO during a pop cycle is not accepted; no entry is lost or duplicated.
- $0 discard: push r1 addr=0 data=1 then addr=9 data=2 → first grant cycle rf_wr=0, next cycle rf_wr=1 with rf_a3=9. chk_a2=0 never gives chk_pend2=1.
- Reset mid-stream: with 3 queued entries, assert rst for one cycle → no further rf_wr pulses, idle=1 next cycle; a new r1 push is then issued normally with requester 0 priority restored.
